freq_period_meter: RTL and testbench
====================================

Name: freq_period_meter

Overview:
Parametrised single-channel frequency/period meter for an asynchronous square-wave input.
- Synchronises IN and measures high and low time in CLK cycles.
- Optionally averages over 2^AVG_LOG2 consecutive periods.
- Computes frequency = CLK_HZ / period with an iterative divider.
- Adds an enable, a valid strobe, saturation/timeout and overflow flags.

Parameters:
CNT_W, 16, width of the high/low cycle counters and of on_count/off_count.
FREQ_W, 12, width of the freq output.
CLK_HZ, 100000000, CLK frequency in Hz; must be < 2^32.
AVG_LOG2, 0, log2 of the number of periods averaged per result; legal range 0..4.

Ports:
CLK  input  1  system clock, rising edge.
RST_N  input  1  reset, asynchronous, active-low.
EN  input  1  measurement enable; low aborts and idles.
IN  input  1  asynchronous signal under test.
on_count  output  CNT_W  averaged high time, in CLK cycles.
off_count  output  CNT_W  averaged low time, in CLK cycles.
period  output  CNT_W+1  on_count + off_count.
freq  output  FREQ_W  floor(CLK_HZ/period), saturated.
valid  output  1  one-cycle pulse when the outputs update.
timeout  output  1  last result aborted by counter saturation.
overflow  output  1  last freq value was saturated.

Behaviour:
Reset and input conditioning
- RST_N low: all state and outputs go to 0; state = IDLE; synchroniser flops = 0.
- IN passes through a 2-flop synchroniser to give s.
- Registered copy s_d; rise = s & ~s_d.

State machine
- IDLE: entered while EN=0. Leaves to ARM when EN=1.
- ARM: waits for rise. On rise: hi=1, lo=0, sums=0, npr=0; go to MEAS.
- MEAS, cycle without rise: hi++ if s=1, else lo++.
- MEAS, rise cycle (closes one period):
  - hsum += hi; lsum += lo; npr++.
  - Then hi=1, lo=0 (the rise cycle belongs to the new period).
  - If npr reaches 2^AVG_LOG2: latch on = hsum>>AVG_LOG2 and off = lsum>>AVG_LOG2, then go to DIV.
- MEAS, saturation: if hi or lo reaches 2^CNT_W-1:
  - on_count = off_count = all ones, period = all ones, freq = 0.
  - timeout = 1, overflow = 0, valid pulse; go to ARM.
- DIV: restoring division of CLK_HZ (32-bit) by (on+off), one quotient bit per cycle, 32 cycles. IN is ignored in this state.
- DONE (1 cycle): register outputs and pulse valid; go to ARM. Measurement windows are therefore non-contiguous.

Width and saturation rules
- Sum registers are CNT_W+AVG_LOG2 bits wide and cannot overflow.
- If the quotient exceeds 2^FREQ_W-1: freq = 2^FREQ_W-1 and overflow = 1; otherwise overflow = 0.
- On a valid non-timeout result, timeout clears to 0.

Latency
- Closing rise at cycle t: DIV occupies t+1..t+32; valid is high at t+33 with the outputs.
- Pin to rise: 2 CLK cycles.

Enable and reset during operation
- EN=0 in any state: next state is IDLE and the partial measurement is discarded.
- Outputs and flags hold their last values; no valid pulse is generated.
- Async reset mid-DIV or mid-MEAS: immediate zeroing; no valid pulse.

Output hold and degenerate inputs
- Outputs change only in DONE or on the timeout event, and hold otherwise.
- valid is never high for two consecutive cycles.
- Minimum measurable period is 2 cycles (hi≥1, lo≥1); divide-by-zero cannot occur.

Test Plan:
1. Bench params CLK_HZ=100000, CNT_W=16, FREQ_W=12, AVG_LOG2=0; EN=1; IN 30 cycles high / 70 low, repeating -> on_count=30, off_count=70, period=100, freq=1000, timeout=0, overflow=0; valid high exactly 33 cycles after the closing rise.
2. AVG_LOG2=2; high/low pairs (50,50),(50,50),(50,50),(50,54) -> on_count=50, off_count=51, period=101, freq=990; exactly one valid pulse per 4 periods.
3. Arm with one rise, then hold IN high -> after 65535 high cycles: timeout=1, on/off=0xFFFF, freq=0, one valid pulse. A subsequent good 30/70 wave -> timeout=0 and correct values.
4. IN 1 high / 1 low (period 2) -> freq=4095, overflow=1. Then a 30/70 wave -> overflow=0, freq=1000.
5. EN dropped mid-MEAS and again mid-DIV -> no valid pulse and outputs hold the previous values. EN re-raised -> the first result arrives only after a fresh rise plus a full period.
6. RST_N pulsed low mid-DIV, asynchronously between clock edges -> all outputs 0 immediately, state IDLE. After release, normal operation resumes.

Source files
------------

// File: rtl/freq_period_meter.sv
// Single-channel frequency/period meter.
// Measures high/low time of an asynchronous square wave in CLK cycles,
// optionally averages over 2^AVG_LOG2 periods, then derives the frequency
// with a 32-cycle restoring divider. Results and flags update only on a
// completed division or on a counter-saturation timeout.
module freq_period_meter #(
  parameter int          CNT_W    = 16,
  parameter int          FREQ_W   = 12,
  parameter logic [31:0] CLK_HZ   = 32'd100000000,
  parameter int          AVG_LOG2 = 0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              EN,
  input  logic              IN,
  output logic [CNT_W-1:0]  on_count,
  output logic [CNT_W-1:0]  off_count,
  output logic [CNT_W:0]    period,
  output logic [FREQ_W-1:0] freq,
  output logic              valid,
  output logic              timeout,
  output logic              overflow
);

  localparam int                SUM_W   = CNT_W + AVG_LOG2;
  localparam logic [CNT_W-1:0]  C_MAXM1 = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic [AVG_LOG2:0] C_NPER  = (AVG_LOG2+1)'(1) << AVG_LOG2;

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_MEAS, S_DIV, S_DONE} state_t;

  state_t              r_state;
  logic                r_s1, r_s2, r_sd;
  logic [CNT_W-1:0]    r_hi, r_lo;
  logic [SUM_W-1:0]    r_hsum, r_lsum;
  logic [AVG_LOG2:0]   r_npr;
  logic [CNT_W-1:0]    r_mon, r_moff;
  logic [CNT_W:0]      r_div;
  logic [CNT_W:0]      r_rem;
  logic [31:0]         r_quo;
  logic [4:0]          r_bit;
  logic [CNT_W-1:0]    r_on, r_off;
  logic [CNT_W:0]      r_period;
  logic [FREQ_W-1:0]   r_freq;
  logic                r_valid, r_timeout, r_overflow;

  logic                w_rise;
  logic [SUM_W-1:0]    w_hsum_nx, w_lsum_nx;
  logic [AVG_LOG2:0]   w_npr_nx;
  logic [CNT_W-1:0]    w_on, w_off;
  logic [CNT_W+1:0]    w_rem_sh;
  logic                w_ge;
  logic [CNT_W:0]      w_rem_nx;
  logic [31:0]         w_quo_nx;
  logic                w_fsat;

  // Two-flop synchroniser plus a delayed copy for rising-edge detection
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_sd <= 1'b0;
    end else begin
      r_s1 <= IN;
      r_s2 <= r_s1;
      r_sd <= r_s2;
    end
  end

  assign w_rise    = r_s2 & ~r_sd;

  // Period accumulation; the average is the top CNT_W bits of each sum
  assign w_hsum_nx = r_hsum + SUM_W'(r_hi);
  assign w_lsum_nx = r_lsum + SUM_W'(r_lo);
  assign w_npr_nx  = r_npr + (AVG_LOG2+1)'(1);
  assign w_on      = w_hsum_nx[SUM_W-1:AVG_LOG2];
  assign w_off     = w_lsum_nx[SUM_W-1:AVG_LOG2];

  // One restoring-division step: dividend bits shift out of r_quo's top
  // while quotient bits shift in at the bottom.
  assign w_rem_sh  = {r_rem, r_quo[31]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_div});
  assign w_rem_nx  = w_ge ? (w_rem_sh[CNT_W:0] - r_div) : w_rem_sh[CNT_W:0];
  assign w_quo_nx  = {r_quo[30:0], w_ge};
  assign w_fsat    = |w_quo_nx[31:FREQ_W];

  // Measurement/division FSM with registered results and flags
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= S_IDLE;
      r_hi       <= '0;
      r_lo       <= '0;
      r_hsum     <= '0;
      r_lsum     <= '0;
      r_npr      <= '0;
      r_mon      <= '0;
      r_moff     <= '0;
      r_div      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_bit      <= '0;
      r_on       <= '0;
      r_off      <= '0;
      r_period   <= '0;
      r_freq     <= '0;
      r_valid    <= 1'b0;
      r_timeout  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (!EN) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: r_state <= S_ARM;
          S_ARM: begin
            if (w_rise) begin
              r_hi    <= CNT_W'(1);
              r_lo    <= '0;
              r_hsum  <= '0;
              r_lsum  <= '0;
              r_npr   <= '0;
              r_state <= S_MEAS;
            end
          end
          S_MEAS: begin
            if (w_rise) begin
              // the rise cycle itself is the first high cycle of the next period
              r_hi   <= CNT_W'(1);
              r_lo   <= '0;
              r_hsum <= w_hsum_nx;
              r_lsum <= w_lsum_nx;
              r_npr  <= w_npr_nx;
              if (w_npr_nx == C_NPER) begin
                r_mon   <= w_on;
                r_moff  <= w_off;
                r_div   <= {1'b0, w_on} + {1'b0, w_off};
                r_rem   <= '0;
                r_quo   <= CLK_HZ;
                r_bit   <= '0;
                r_state <= S_DIV;
              end
            end else if (r_s2 ? (r_hi == C_MAXM1) : (r_lo == C_MAXM1)) begin
              // a counter would hit all-ones: report the stuck input and re-arm
              r_on       <= '1;
              r_off      <= '1;
              r_period   <= '1;
              r_freq     <= '0;
              r_timeout  <= 1'b1;
              r_overflow <= 1'b0;
              r_valid    <= 1'b1;
              r_state    <= S_ARM;
            end else if (r_s2) begin
              r_hi <= r_hi + CNT_W'(1);
            end else begin
              r_lo <= r_lo + CNT_W'(1);
            end
          end
          S_DIV: begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            r_bit <= r_bit + 5'd1;
            if (r_bit == 5'd31) begin
              // final quotient bit is formed this cycle, so publish directly
              r_on       <= r_mon;
              r_off      <= r_moff;
              r_period   <= r_div;
              r_freq     <= w_fsat ? '1 : w_quo_nx[FREQ_W-1:0];
              r_overflow <= w_fsat;
              r_timeout  <= 1'b0;
              r_valid    <= 1'b1;
              r_state    <= S_DONE;
            end
          end
          S_DONE:  r_state <= S_ARM;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign on_count  = r_on;
  assign off_count = r_off;
  assign period    = r_period;
  assign freq      = r_freq;
  assign valid     = r_valid;
  assign timeout   = r_timeout;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_freq_period_meter.sv
// Directed bench for freq_period_meter: two instances (no averaging and
// 4-period averaging) driven by square waves built from high/low lengths.
module tb_freq_period_meter;

  logic        CLK, RST_N, EN, in_a, in_b;
  logic [15:0] on0, off0, on1, off1;
  logic [16:0] per0, per1;
  logic [11:0] fq0, fq1;
  logic        valid0, to0, ov0, valid1, to1, ov1;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int vcnt0 = 0, vcnt1 = 0, vcyc0 = 0, vcyc1 = 0;
  int dbl   = 0;
  int rise_cyc = 0;
  bit pv0 = 0, pv1 = 0;

  freq_period_meter #(.CNT_W(16), .FREQ_W(12), .CLK_HZ(32'd100000), .AVG_LOG2(0)) dut0 (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .IN(in_a),
    .on_count(on0), .off_count(off0), .period(per0), .freq(fq0),
    .valid(valid0), .timeout(to0), .overflow(ov0));

  freq_period_meter #(.CNT_W(16), .FREQ_W(12), .CLK_HZ(32'd100000), .AVG_LOG2(2)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .IN(in_b),
    .on_count(on1), .off_count(off1), .period(per1), .freq(fq1),
    .valid(valid1), .timeout(to1), .overflow(ov1));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // valid-pulse bookkeeping, sampled away from the active edge
  always @(negedge CLK) begin
    if (valid0) begin vcnt0++; vcyc0 = cyc; end
    if (valid1) begin vcnt1++; vcyc1 = cyc; end
    if ((valid0 && pv0) || (valid1 && pv1)) dbl++;
    pv0 = valid0;
    pv1 = valid1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // one period on the selected input: rise at the first negedge
  task automatic wave(input bit b, input int hi, input int lo);
    @(negedge CLK);
    if (b) in_b = 1'b1; else in_a = 1'b1;
    rise_cyc = cyc;
    repeat (hi) @(negedge CLK);
    if (b) in_b = 1'b0; else in_a = 1'b0;
    repeat (lo - 1) @(negedge CLK);
  endtask

  task automatic wait_v0(input string tag, input int start, input int budget);
    int n;
    n = 0;
    while (vcnt0 == start && n < budget) begin
      @(negedge CLK);
      n++;
    end
    chk(tag, 32'(vcnt0 != start), 32'd1);
  endtask

  task automatic chk0(input string tag, input int on, input int off, input int per,
                      input int f, input bit t, input bit o);
    chk({tag, "_on"},  32'(on0),  32'(on));
    chk({tag, "_off"}, 32'(off0), 32'(off));
    chk({tag, "_per"}, 32'(per0), 32'(per));
    chk({tag, "_frq"}, 32'(fq0),  32'(f));
    chk({tag, "_to"},  32'(to0),  32'(t));
    chk({tag, "_ov"},  32'(ov0),  32'(o));
  endtask

  initial begin
    int vc, rc;
    RST_N = 1'b0; EN = 1'b0; in_a = 1'b0; in_b = 1'b0;
    repeat (3) @(negedge CLK);
    chk0("rst", 0, 0, 0, 0, 0, 0);
    chk("rst_valid", 32'(valid0), 32'd0);
    chk("rst_frq1", 32'(fq1), 32'd0);
    RST_N = 1'b1;
    EN    = 1'b1;
    repeat (3) @(negedge CLK);

    // 1: 30/70 wave, latency from closing rise
    vc = vcnt0;
    wave(0, 30, 70);
    wave(0, 30, 70);
    chk("t1_nvalid", 32'(vcnt0 - vc), 32'd1);
    chk("t1_lat", 32'(vcyc0 - rise_cyc), 32'd35);
    chk0("t1", 30, 70, 100, 1000, 0, 0);

    // 2: four-period average on the second instance
    vc = vcnt1;
    wave(1, 50, 50); wave(1, 50, 50); wave(1, 50, 50); wave(1, 50, 54);
    chk("t2_early", 32'(vcnt1 - vc), 32'd0);
    @(negedge CLK); in_b = 1'b1; rc = cyc;
    repeat (10) @(negedge CLK); in_b = 1'b0;
    repeat (40) @(negedge CLK);
    chk("t2_nvalid", 32'(vcnt1 - vc), 32'd1);
    chk("t2_lat", 32'(vcyc1 - rc), 32'd35);
    chk("t2_on", 32'(on1), 32'd50);
    chk("t2_off", 32'(off1), 32'd51);
    chk("t2_per", 32'(per1), 32'd101);
    chk("t2_frq", 32'(fq1), 32'd990);
    chk("t2_to", 32'(to1), 32'd0);
    chk("t2_ov", 32'(ov1), 32'd0);

    // 3: stuck-high input saturates the high counter
    vc = vcnt0;
    @(negedge CLK); in_a = 1'b1;
    wait_v0("t3_wait", vc, 70000);
    chk0("t3", 16'hFFFF, 16'hFFFF, 17'h1FFFF, 0, 1, 0);
    repeat (5) @(negedge CLK);
    chk("t3_nvalid", 32'(vcnt0 - vc), 32'd1);
    in_a = 1'b0;
    repeat (5) @(negedge CLK);
    wave(0, 30, 70);
    wave(0, 30, 70);
    chk("t3_nvalid2", 32'(vcnt0 - vc), 32'd2);
    chk0("t3b", 30, 70, 100, 1000, 0, 0);

    // 4: minimum period saturates freq
    vc = vcnt0;
    repeat (4) wave(0, 1, 1);
    repeat (40) @(negedge CLK);
    chk("t4_nvalid", 32'(vcnt0 - vc), 32'd1);
    chk0("t4", 1, 1, 2, 4095, 0, 1);
    wave(0, 30, 70);
    wave(0, 30, 70);
    chk0("t4b", 30, 70, 100, 1000, 0, 0);

    // 5: enable dropped mid-MEAS and mid-DIV
    vc = vcnt0;
    @(negedge CLK); in_a = 1'b1;
    repeat (10) @(negedge CLK); EN = 1'b0;
    repeat (5)  @(negedge CLK); EN = 1'b1;
    repeat (5)  @(negedge CLK); in_a = 1'b0;
    repeat (60) @(negedge CLK);
    wave(0, 20, 60);
    @(negedge CLK); in_a = 1'b1;
    repeat (12) @(negedge CLK); EN = 1'b0; in_a = 1'b0;
    repeat (40) @(negedge CLK);
    chk("t5_nvalid", 32'(vcnt0 - vc), 32'd0);
    chk0("t5", 30, 70, 100, 1000, 0, 0);
    EN = 1'b1;
    wave(0, 40, 60);
    chk("t5_early", 32'(vcnt0 - vc), 32'd0);
    wave(0, 40, 60);
    chk("t5_nvalid2", 32'(vcnt0 - vc), 32'd1);
    chk("t5_lat", 32'(vcyc0 - rise_cyc), 32'd35);
    chk0("t5b", 40, 60, 100, 1000, 0, 0);

    // 6: asynchronous reset in the middle of a division
    wave(0, 30, 70);
    @(negedge CLK); in_a = 1'b1;
    repeat (12) @(negedge CLK);
    @(posedge CLK);
    #3 RST_N = 1'b0;
    #1;
    chk0("t6", 0, 0, 0, 0, 0, 0);
    chk("t6_valid", 32'(valid0), 32'd0);
    in_a = 1'b0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    vc = vcnt0;
    repeat (40) @(negedge CLK);
    chk("t6_novalid", 32'(vcnt0 - vc), 32'd0);
    wave(0, 30, 70);
    wave(0, 30, 70);
    chk("t6_nvalid", 32'(vcnt0 - vc), 32'd1);
    chk0("t6b", 30, 70, 100, 1000, 0, 0);

    chk("dbl_valid", 32'(dbl), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
